// File: rtl/aegnn_pkg.sv
// Shared pixel-index types and downsampling-radius tables for the neighbor streaming blocks.
package aegnn;

    localparam int TOT_PIXEL       = 1024;
    localparam int MAX_DS_RANGE    = 25;
    localparam int PIXEL_W         = $clog2(TOT_PIXEL);
    localparam int PIXEL_IDX_WIDTH = $clog2(TOT_PIXEL) + 2;

    typedef logic signed [PIXEL_IDX_WIDTH-1:0] pixel_idx_t;
    typedef logic [4:0]                        ds_slot_t;

    // Number of leading slots that lie within L1 radius 0..3.
    localparam int DS_RADIUS_SLOTS [4] = '{1, 5, 13, 25};

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

endpackage

// File: rtl/neighbor_pixel_stream_first_set_idx.sv
// Combinational priority encoder: index of the lowest set bit of vec.
module first_set_idx
    import aegnn::*;
#(
    parameter int unsigned WIDTH = MAX_DS_RANGE
) (
    input  logic [WIDTH-1:0] vec,
    output ds_slot_t         idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ds_slot_t'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/neighbor_pixel_stream.sv
// Streams the legal pixels of a neighbor list one beat per handshake.
// Optional build macro NEIGHBOR_SKIP_SELF_EN suppresses the center slot 0.
module neighbor_pixel_stream
    import aegnn::*;
#(
    parameter int unsigned NB_SLOTS = MAX_DS_RANGE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  pixel_idx_t         neighbor_pixels [NB_SLOTS],
    input  logic [1:0]         radius,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_pixel,
    output ds_slot_t           out_slot,
    output logic               out_last,
    output logic               done
);

    state_t              state;
    logic [NB_SLOTS-1:0] mask, mask_new, mask_nxt;
    pixel_idx_t          list_q [NB_SLOTS];
    pixel_idx_t          sel_src;
    ds_slot_t            sel_idx;
    logic                sel_any, sel_last;
    logic                capture, fire;

    assign capture = in_valid && in_ready;
    assign fire    = out_valid && out_ready;

    // Legality is checked on the signed entry before the sign bit is dropped.
    always_comb begin
        mask_new = '0;
        for (int i = 0; i < int'(NB_SLOTS); i++) begin
            mask_new[i] = (neighbor_pixels[i] >= 0) && (int'(neighbor_pixels[i]) < TOT_PIXEL) &&
                          (i < DS_RADIUS_SLOTS[radius]);
        end
`ifdef NEIGHBOR_SKIP_SELF_EN
        mask_new[0] = 1'b0;
`endif
    end

    always_comb begin
        mask_nxt = mask;
        if (capture) begin
            mask_nxt = mask_new;
        end else if (fire) begin
            mask_nxt = mask & ~(NB_SLOTS'(1) << out_slot);
        end
    end

    first_set_idx #(
        .WIDTH (NB_SLOTS)
    ) u_first_set_idx (
        .vec (mask_nxt),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Outputs are registered from next-cycle mask, so the captured list is read directly.
    assign sel_src  = capture ? neighbor_pixels[sel_idx] : list_q[sel_idx];
    assign sel_last = sel_any && ((mask_nxt & (mask_nxt - NB_SLOTS'(1))) == '0);

    always_ff @(posedge clk) begin
        if (capture) begin
            list_q <= neighbor_pixels;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            mask      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_slot  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            mask      <= mask_nxt;
            out_pixel <= sel_any ? sel_src[PIXEL_W-1:0] : '0;
            out_slot  <= sel_any ? sel_idx : '0;
            out_last  <= sel_last;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            case (state)
                StIdle: begin
                    if (capture) begin
                        state     <= sel_any ? StScan : StDone;
                        out_valid <= sel_any;
                        done      <= !sel_any;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                StScan: begin
                    if (fire && out_last) begin
                        state     <= StDone;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                StDone: begin
                    state    <= StIdle;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= StIdle;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neighbor_pixel_stream.sv
// Directed bench for neighbor_pixel_stream with a beat scoreboard; honours NEIGHBOR_SKIP_SELF_EN.
module tb_neighbor_pixel_stream;
    import aegnn::*;

    localparam int NB = MAX_DS_RANGE;

    typedef struct {
        int pixel;
        int slot;
        int last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    pixel_idx_t         pix_tb [NB];
    logic [1:0]         radius;
    logic               out_valid;
    logic               out_ready;
    logic [PIXEL_W-1:0] out_pixel;
    ds_slot_t           out_slot;
    logic               out_last;
    logic               done;

    beat_t sb[$];
    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;
    int    done_cnt = 0;
    logic  out_valid_s, in_ready_s, done_s;

    always #5 clk = ~clk;

    neighbor_pixel_stream #(
        .NB_SLOTS (NB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .neighbor_pixels (pix_tb),
        .radius          (radius),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pixel       (out_pixel),
        .out_slot        (out_slot),
        .out_last        (out_last),
        .done            (done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Sample at the falling edge, then advance past the next rising edge.
    task automatic tick();
        beat_t e;
        @(negedge clk);
        out_valid_s = out_valid;
        in_ready_s  = in_ready;
        done_s      = done;
        if (done) done_cnt++;
        if (out_valid && !rst) begin
            if (sb.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = sb[0];
                chk("beat_slot", int'(out_slot), e.slot);
                chk("beat_pixel", int'(out_pixel), e.pixel);
                chk("beat_last", int'(out_last), e.last);
                if (out_ready) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int radius_limit(input int rad);
        case (rad)
            0:       return 1;
            1:       return 5;
            2:       return 13;
            default: return 25;
        endcase
    endfunction

    function automatic bit slot_legal(input int i, input int rad);
        bit ok;
        ok = (i < radius_limit(rad)) && (pix_tb[i] >= 0) && (int'(pix_tb[i]) < TOT_PIXEL);
`ifdef NEIGHBOR_SKIP_SELF_EN
        if (i == 0) ok = 1'b0;
`endif
        return ok;
    endfunction

    function automatic int push_expected(input int rad);
        int    k = 0;
        int    n = 0;
        beat_t b;
        for (int i = 0; i < NB; i++) if (slot_legal(i, rad)) k++;
        for (int i = 0; i < NB; i++) begin
            if (slot_legal(i, rad)) begin
                n++;
                b.pixel = int'(pix_tb[i]) % TOT_PIXEL;
                b.slot  = i;
                b.last  = (n == k) ? 1 : 0;
                sb.push_back(b);
            end
        end
        return k;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        chk(tag, int'(in_ready), 1);
    endtask

    task automatic run_list(input string tag, input int rad, input int stall_beat,
                            input int stall_len);
        int k, t, dcyc, stalls, c;
        bit seen;
        sb.delete();
        out_ready = 1'b1;
        wait_ready({tag, "_ready"});
        k = push_expected(rad);
        radius   = rad[1:0];
        in_valid = 1'b1;
        t = cyc;
        tick();
        in_valid = 1'b0;
        seen   = 1'b0;
        stalls = 0;
        dcyc   = -1;
        for (int n = 0; n < 200 && !seen; n++) begin
            if ((k - sb.size()) == stall_beat && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            c = cyc;
            tick();
            if (done_s) begin
                seen = 1'b1;
                dcyc = c;
            end
        end
        out_ready = 1'b1;
        chk({tag, "_done_cycle"}, dcyc, t + k + 1 + stall_len);
        chk({tag, "_beats_left"}, sb.size(), 0);
        tick();
        chk({tag, "_in_ready_back"}, int'(in_ready_s), 1);
        chk({tag, "_done_single"}, int'(done_s), 0);
    endtask

    initial begin
        int d0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        radius    = 2'd0;
        for (int i = 0; i < NB; i++) pix_tb[i] = -1;
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_slot", int'(out_slot), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", int'(in_ready), 1);

        // 25 ascending pixels, full radius.
        for (int i = 0; i < NB; i++) pix_tb[i] = pixel_idx_t'(100 + i);
        run_list("full25", 3, -1, 0);

        // Holes in slots 2,3; slots beyond radius 1 are legal but out of range.
        for (int i = 0; i < NB; i++) pix_tb[i] = pixel_idx_t'(200);
        pix_tb[0] = 7;
        pix_tb[1] = 9;
        pix_tb[2] = -1;
        pix_tb[3] = -1;
        pix_tb[4] = 5;
        run_list("holes_r1", 1, -1, 0);

        // Back-pressure on the second beat for three cycles.
        run_list("stall", 1, 1, 3);

        for (int i = 0; i < NB; i++) pix_tb[i] = -1;
        run_list("all_neg", 3, -1, 0);

        pix_tb[5] = pixel_idx_t'(TOT_PIXEL);
        run_list("tot_pixel", 2, -1, 0);

        // Boundary values around the legal range.
        for (int i = 0; i < NB; i++) pix_tb[i] = -1;
        pix_tb[0]  = 0;
        pix_tb[3]  = pixel_idx_t'(TOT_PIXEL - 1);
        pix_tb[7]  = pixel_idx_t'(TOT_PIXEL + 1);
        pix_tb[9]  = pixel_idx_t'(-TOT_PIXEL);
        pix_tb[12] = pixel_idx_t'(513);
        pix_tb[13] = pixel_idx_t'(44);
        run_list("bounds_r2", 2, -1, 0);

        for (int i = 0; i < NB; i++) begin
            case ($urandom_range(0, 3))
                0:       pix_tb[i] = -1;
                1:       pix_tb[i] = pixel_idx_t'(TOT_PIXEL + int'($urandom_range(0, 500)));
                default: pix_tb[i] = pixel_idx_t'($urandom_range(0, TOT_PIXEL - 1));
            endcase
        end
        pix_tb[0] = pixel_idx_t'(321);
        run_list("mixed_r3", 3, 2, 2);
        run_list("mixed_r0", 0, -1, 0);

        // Reset in the middle of a list.
        for (int i = 0; i < NB; i++) pix_tb[i] = -1;
        for (int i = 0; i < 5; i++) pix_tb[i] = pixel_idx_t'(10 + i);
        sb.delete();
        wait_ready("midrst_ready");
        void'(push_expected(1));
        radius   = 2'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        chk("midrst_out_valid", int'(out_valid_s), 0);
        chk("midrst_in_ready_low", int'(in_ready_s), 0);
        wait_ready("midrst_in_ready");
        tick();
        chk("midrst_no_done", done_cnt, d0);

        for (int i = 0; i < NB; i++) pix_tb[i] = pixel_idx_t'(100 + i);
        run_list("after_rst", 3, -1, 0);

`ifdef NEIGHBOR_SKIP_SELF_EN
        for (int i = 0; i < NB; i++) pix_tb[i] = pixel_idx_t'(50 + i);
        run_list("skip_r1", 1, -1, 0);
        run_list("skip_r0", 0, -1, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
